fir_tap_sequencer: RTL and testbench

Time-multiplexed single-multiplier FIR engine that drives a shared combinational 16s×12u→28 multiplier. It is the initiator side of that multiplier interface: per accepted input sample it sequences NTAPS operand pairs (delay-line sample, coefficient), accumulates the returned products and emits one requantized 16-bit output. It sits between the filterbank's per-channel sample stream and the decimation/output stage.

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_tap_sequencer_if.sv | 24 ++
 rtl/fir_requant.sv | 42 ++++
 rtl/fir_tap_sequencer.sv | 105 ++++++++++
 tb/tb_fir_tap_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the time-multiplexed FIR tap sequencer.
package fir_pkg;
  localparam int NTAPS     = 32;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 12;
  localparam int PROD_W    = 28;
  localparam int TAP_W     = $clog2(NTAPS);
  localparam int ACC_W     = PROD_W + TAP_W;
  localparam int OUT_SHIFT = 11;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  typedef logic [TAP_W-1:0] tap_t;
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample stream, output stream and coefficient write port of the FIR tap sequencer.
interface fir_tap_sequencer_if;
  import fir_pkg::*;

  logic signed [DATA_W-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     coef_we;
  tap_t                     coef_addr;
  logic [COEF_W-1:0]        coef_wdata;

  modport master (
    output s_data, s_valid, m_ready, coef_we, coef_addr, coef_wdata,
    input  s_ready, m_data, m_valid
  );

  modport slave (
    input  s_data, s_valid, m_ready, coef_we, coef_addr, coef_wdata,
    output s_ready, m_data, m_valid
  );
endinterface

// File: rtl/fir_requant.sv
// Accumulator-to-sample requantizer. FIR_ROUND_SAT_EN selects round-half-up with
// saturation; otherwise floor shift with two's-complement wrap.
module fir_requant
  import fir_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] data_o
);

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  // One guard bit keeps the rounding offset from overflowing the accumulator range.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = {a[ACC_W-1], a};
    t = t + HALF;
    return t >>> OUT_SHIFT;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  assign data_o = saturate(round_shift(acc_i));
`else
  function automatic logic signed [ACC_W-1:0] floor_shift(input logic signed [ACC_W-1:0] a);
    return a >>> OUT_SHIFT;
  endfunction

  function automatic logic signed [DATA_W-1:0] wrap(input logic signed [ACC_W-1:0] v);
    return v[DATA_W-1:0];
  endfunction

  assign data_o = wrap(floor_shift(acc_i));
`endif

endmodule

// File: rtl/fir_tap_sequencer.sv
// Single-multiplier FIR engine: one sample in, NTAPS MAC cycles on an external
// multiplier, one requantized sample out. Output format set by FIR_ROUND_SAT_EN.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  fir_tap_sequencer_if.slave       bus,
  output logic signed [DATA_W-1:0] mul_a,
  output logic [COEF_W-1:0]        mul_b,
  input  logic signed [PROD_W-1:0] mul_p,
  output logic                     busy
);

  state_t                   state_q;
  tap_t                     wr_ptr_q;
  tap_t                     k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [DATA_W-1:0] dline_q [NTAPS];
  logic [COEF_W-1:0]        coef_q  [NTAPS];
  logic signed [DATA_W-1:0] m_data_q;
  logic                     m_valid_q;
  logic                     s_ready_q;
  logic                     busy_q;
  logic signed [DATA_W-1:0] req_data;
  tap_t                     rd_idx;

  // wr_ptr already points past the newest sample while in MAC.
  assign rd_idx   = wr_ptr_q - tap_t'(1) - k_q;
  assign prod_ext = {{(ACC_W-PROD_W){mul_p[PROD_W-1]}}, mul_p};
  assign acc_d    = acc_q + prod_ext;

  assign mul_a = (state_q == MAC) ? dline_q[rd_idx] : '0;
  assign mul_b = (state_q == MAC) ? coef_q[k_q]     : '0;

  // Requantize the final sum so m_data is registered on the same edge OUT is entered.
  fir_requant u_requant (
    .acc_i  (acc_d),
    .data_o (req_data)
  );

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign busy        = busy_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          s_ready_q <= 1'b1;
          if (bus.coef_we) coef_q[bus.coef_addr] <= bus.coef_wdata;
          if (bus.s_valid && s_ready_q) begin
            dline_q[wr_ptr_q] <= bus.s_data;
            wr_ptr_q          <= wr_ptr_q + tap_t'(1);
            acc_q             <= '0;
            k_q               <= '0;
            s_ready_q         <= 1'b0;
            busy_q            <= 1'b1;
            state_q           <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + tap_t'(1);
          if (k_q == tap_t'(NTAPS - 1)) begin
            m_data_q  <= req_data;
            m_valid_q <= 1'b1;
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer; the reference model follows FIR_ROUND_SAT_EN.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  fir_tap_sequencer_if bus();

  logic signed [DATA_W-1:0] mul_a;
  logic [COEF_W-1:0]        mul_b;
  logic signed [PROD_W-1:0] mul_p;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic                     busy;

  // External combinational multiplier: signed sample times unsigned coefficient.
  assign a_ext = PROD_W'(mul_a);
  assign b_ext = PROD_W'({1'b0, mul_b});
  assign mul_p = a_ext * b_ext;

  fir_tap_sequencer dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus.slave),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_p  (mul_p),
    .busy   (busy)
  );

  int dl_m [NTAPS];
  int cf_m [NTAPS];
  int wp_m;
  logic signed [DATA_W-1:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic logic signed [DATA_W-1:0] model_out();
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < NTAPS; k++)
      acc += longint'(cf_m[k]) * longint'(dl_m[(wp_m - 1 - k) & (NTAPS - 1)]);
`ifdef FIR_ROUND_SAT_EN
    r = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = acc >>> OUT_SHIFT;
`endif
    return DATA_W'(r);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      dl_m[i] = 0;
      cf_m[i] = 0;
    end
    wp_m = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.coef_we = 1'b0;
    tick();
    model_clear();
    ap_rst = 1'b0;
    tick();
  endtask

  task automatic write_coef(input int a, input int v);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = tap_t'(a);
    bus.coef_wdata = COEF_W'(v);
    tick();
    bus.coef_we = 1'b0;
    cf_m[a] = v;
  endtask

  task automatic send_sample(input int v, input bit cw = 1'b0, input int ca = 0, input int cv = 0);
    int n;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.s_ready) begin
      total++; bad++;
      $display("FAIL s_ready_timeout: got s_ready=%0b required 1", bus.s_ready);
      return;
    end
    bus.s_data     = DATA_W'(v);
    bus.s_valid    = 1'b1;
    bus.coef_we    = cw;
    bus.coef_addr  = tap_t'(ca);
    bus.coef_wdata = COEF_W'(cv);
    tick();
    bus.s_valid = 1'b0;
    bus.coef_we = 1'b0;
    last_acc = cyc;
    if (cw) cf_m[ca] = cv;
    dl_m[wp_m] = v;
    wp_m = (wp_m + 1) % NTAPS;
    exp_q.push_back(model_out());
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.m_valid && n < 200) begin
      tick();
      n++;
    end
    if (!bus.m_valid) begin
      total++; bad++;
      $display("FAIL %s_timeout: got m_valid=%0b required 1", name, bus.m_valid);
    end
  endtask

  task automatic recv(input int hold, input string name);
    logic signed [DATA_W-1:0] e;
    logic signed [DATA_W-1:0] first;
    wait_valid(name);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_empty: got m_data=%0d required no output", name, bus.m_data);
      return;
    end
    e = exp_q.pop_front();
    first = bus.m_data;
    for (int i = 0; i < hold; i++) begin
      bus.s_data  = DATA_W'(16'h5A5A + i);
      bus.s_valid = 1'b1;
      tick();
      total++;
      if (bus.m_data !== first || bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_hold: got m_data=%0d m_valid=%0b s_ready=%0b required %0d 1 0",
                 name, bus.m_data, bus.m_valid, bus.s_ready, first);
      end
    end
    bus.s_valid = 1'b0;
    total++;
    if (bus.m_data !== e) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, bus.m_data, e);
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    total++;
    if (bus.m_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drop: got m_valid=%0b required 0", name, bus.m_valid);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    tick();
    total++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || busy !== 1'b0 ||
        bus.m_data !== '0 || mul_a !== '0 || mul_b !== '0) begin
      bad++;
      $display("FAIL reset_state: got s_ready=%0b m_valid=%0b busy=%0b m_data=%0d mul_a=%0d mul_b=%0d required all 0",
               bus.s_ready, bus.m_valid, busy, bus.m_data, mul_a, mul_b);
    end
    model_clear();
    ap_rst = 1'b0;
    tick();
    total++;
    if (bus.s_ready !== 1'b1 || bus.m_data !== '0) begin
      bad++;
      $display("FAIL reset_release: got s_ready=%0b m_data=%0d required 1 0", bus.s_ready, bus.m_data);
    end
    write_coef(0, 2048);
    write_coef(1, 2048);
    send_sample(1234);
    recv(0, "pre_reset");
    // Abort in MAC: outputs fall without a clock edge.
    send_sample(4321);
    repeat (5) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_mac: got %0b required 1", busy);
    end
    ap_rst = 1'b1;
    #1;
    total++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_mac: got m_valid=%0b busy=%0b required 0 0", bus.m_valid, busy);
    end
    model_clear();
    tick();
    ap_rst = 1'b0;
    tick();
    write_coef(0, 2048);
    write_coef(1, 2048);
    send_sample(500);
    recv(0, "after_reset");
    // Abort in OUT.
    send_sample(600);
    wait_valid("out_abort");
    ap_rst = 1'b1;
    #1;
    total++;
    if (bus.m_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_out: got m_valid=%0b required 0", bus.m_valid);
    end
    model_clear();
    tick();
    ap_rst = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    int cnt;
    do_reset();
    write_coef(0, 2048);
    send_sample(1000);
    total++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL identity_start: got m_valid=%0b busy=%0b required 0 1", bus.m_valid, busy);
    end
    cnt = 1;
    while (!bus.m_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    total++;
    if (cnt !== NTAPS + 1) begin
      bad++;
      $display("FAIL identity_latency: got %0d cycles required %0d", cnt, NTAPS + 1);
    end
    recv(0, "identity");
  endtask

  task automatic test_delay();
    int vals [4] = '{100, 200, 300, 400};
    do_reset();
    write_coef(3, 2048);
    foreach (vals[i]) begin
      send_sample(vals[i]);
      recv(0, "delay");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 4095);
    for (int i = 0; i < NTAPS; i++) begin
      send_sample(32767);
      recv(0, "sat_pos");
    end
    for (int i = 0; i < NTAPS; i++) begin
      send_sample(-32768);
      recv(0, "sat_neg");
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    write_coef(0, 2048);
    write_coef(1, 1024);
    send_sample(1000);
    recv(10, "backpressure");
    send_sample(2000);
    recv(0, "bp_history");
  endtask

  task automatic test_coef_busy();
    do_reset();
    write_coef(0, 2048);
    send_sample(700);
    repeat (3) tick();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    tick();
    bus.coef_we = 1'b0;
    recv(0, "coef_busy_ignored");
    write_coef(0, 0);
    send_sample(800);
    recv(0, "coef_idle_applied");
  endtask

  task automatic test_back_to_back();
    int vals [4] = '{100, -200, 300, -400};
    int prev;
    logic signed [DATA_W-1:0] e;
    do_reset();
    write_coef(0, 2048);
    bus.m_ready = 1'b1;
    prev = 0;
    foreach (vals[i]) begin
      // First sample also writes coef[2] in the accept cycle.
      send_sample(vals[i], i == 0, 2, 1024);
      if (i > 0) begin
        total++;
        if (last_acc - prev !== NTAPS + 2) begin
          bad++;
          $display("FAIL b2b_period: got %0d required %0d", last_acc - prev, NTAPS + 2);
        end
      end
      prev = last_acc;
      wait_valid("b2b");
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      total++;
      if (bus.m_data !== e) begin
        bad++;
        $display("FAIL b2b_data: got %0d required %0d", bus.m_data, e);
      end
    end
    tick();
    bus.m_ready = 1'b0;
  endtask

  initial begin
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.m_ready    = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    model_clear();
    test_reset();
    test_identity();
    test_delay();
    test_saturation();
    test_backpressure();
    test_coef_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
